// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one single-port fixed-latency memory.
// Each access is sequenced IDLE -> ISSUE -> WAIT -> RESP and completes with a one-cycle ready pulse.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                ram_en,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam logic [3:0] LP_LAT_M1 = 4'(MEM_LAT - 1);
    localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]          r_wait_cnt;
    logic [3:0]          r_starve_cnt;
    logic                r_gnt_d;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [DATA_W/8-1:0] r_ram_be;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_if_ready;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_grant;
    logic w_sel_d;
    logic w_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_sample = 1'b0;
        // Data has priority unless the fetch port has been passed over STARVE_MAX times in a row.
        w_sel_d  = d_req && !(if_req && (r_starve_cnt == LP_STARVE));
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_grant = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_sample = 1'b1;
                    w_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_gnt_d      <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_be     <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            // ram_en is registered from the grant so it is high exactly during ISSUE.
            r_ram_en   <= w_grant;
            r_if_ready <= w_sample && !r_gnt_d;
            r_d_ready  <= w_sample && r_gnt_d;

            if (w_grant) begin
                r_gnt_d <= w_sel_d;
                if (w_sel_d) begin
                    r_ram_addr  <= d_addr;
                    r_ram_we    <= d_we;
                    r_ram_be    <= d_we ? d_be : '1;
                    r_ram_wdata <= d_wdata;
                    if (!if_req) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != LP_STARVE) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end else begin
                    r_ram_addr   <= if_addr;
                    r_ram_we     <= 1'b0;
                    r_ram_be     <= '1;
                    r_ram_wdata  <= '0;
                    r_starve_cnt <= '0;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= LP_LAT_M1;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_sample) begin
                if (r_gnt_d) begin
                    r_d_rdata <= r_ram_we ? '0 : ram_rdata;
                end else begin
                    r_if_rdata <= ram_rdata;
                end
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_be    = r_ram_be;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = d_req & ~r_d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model of grant order, completion timing and memory contents.
module tb_unified_mem_arbiter;

    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        u1_if_req;
    logic [31:0] u1_if_addr;
    logic [31:0] u1_if_rdata;
    logic        u1_if_ready;
    logic        u1_d_req;
    logic        u1_d_we;
    logic [31:0] u1_d_addr;
    logic [31:0] u1_d_wdata;
    logic [3:0]  u1_d_be;
    logic [31:0] u1_d_rdata;
    logic        u1_d_ready;
    logic        u1_stall_if;
    logic        u1_stall_mem;
    logic        u1_ram_en;
    logic        u1_ram_we;
    logic [3:0]  u1_ram_be;
    logic [31:0] u1_ram_addr;
    logic [31:0] u1_ram_wdata;
    logic [31:0] u1_ram_rdata;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready), .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut_lat1 (
        .clk(clk), .reset(reset),
        .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ready(u1_if_ready),
        .d_req(u1_d_req), .d_we(u1_d_we), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata), .d_be(u1_d_be),
        .d_rdata(u1_d_rdata), .d_ready(u1_d_ready), .stall_if(u1_stall_if), .stall_mem(u1_stall_mem),
        .ram_en(u1_ram_en), .ram_we(u1_ram_we), .ram_be(u1_ram_be), .ram_addr(u1_ram_addr),
        .ram_wdata(u1_ram_wdata), .ram_rdata(u1_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0051_0093 : (32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101));
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Memory macro stand-in: read data appears only in the cycle MEM_LAT after ram_en, junk otherwise.
    logic [31:0] mem [16];
    initial begin
        int          pend;
        logic [31:0] rd_word;
        for (int i = 0; i < 16; i++) mem[i] = init_word(i);
        pend      = 0;
        rd_word   = '0;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) pend = 0;
            if (pend > 0) begin
                pend--;
                ram_rdata = (pend == 0) ? rd_word : $urandom;
            end else begin
                ram_rdata = $urandom;
            end
            if (ram_en === 1'b1) begin
                if (ram_we) begin
                    mem[ram_addr[5:2]] = merge_be(mem[ram_addr[5:2]], ram_wdata, ram_be);
                end else begin
                    rd_word = mem[ram_addr[5:2]];
                    pend    = LAT;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction-level view of the arbiter.
    logic [31:0] ref_mem [16];
    int          c;
    int          free_at;
    int          exp_en, exp_if_rdy, exp_d_rdy;
    int          starve;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] pend_if, pend_d, held_if, held_d;
    int          t_if_last, t_d_last;
    int          rate_if, rate_d;

    task automatic model_reset();
        free_at    = c;
        exp_en     = -1;
        exp_if_rdy = -1;
        exp_d_rdy  = -1;
        starve     = 0;
        held_if    = '0;
        held_d     = '0;
    endtask

    task automatic model_grant();
        bit take_d;
        if (reset && (c >= free_at) && (if_req || d_req)) begin
            take_d = d_req && !(if_req && (starve == SMAX));
            if (take_d) begin
                starve    = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                exp_d_rdy = c + LAT + 2;
                exp_addr  = d_addr;
                exp_we    = d_we;
                exp_be    = d_we ? d_be : 4'hF;
                exp_wdata = d_wdata;
                if (d_we) begin
                    ref_mem[d_addr[5:2]] = merge_be(ref_mem[d_addr[5:2]], d_wdata, d_be);
                    pend_d = '0;
                end else begin
                    pend_d = ref_mem[d_addr[5:2]];
                end
            end else begin
                starve     = 0;
                exp_if_rdy = c + LAT + 2;
                exp_addr   = if_addr;
                exp_we     = 1'b0;
                exp_be     = 4'hF;
                pend_if    = ref_mem[if_addr[5:2]];
            end
            exp_en  = c + 1;
            free_at = c + LAT + 3;
        end
    endtask

    task automatic new_fetch();
        if_req  = 1'b1;
        if_addr = $urandom & 32'h0000_003C;
    endtask

    task automatic new_data();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom & 32'h0000_013C;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic step();
        model_grant();
        @(negedge clk);
        c++;
        chk("ram_en", 32'(ram_en), 32'(c == exp_en));
        if (c == exp_en) begin
            chk("ram_addr", ram_addr, exp_addr);
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            chk("ram_be", 32'(ram_be), 32'(exp_be));
            if (exp_we) chk("ram_wdata", ram_wdata, exp_wdata);
        end
        if (c == exp_if_rdy) held_if = pend_if;
        if (c == exp_d_rdy)  held_d  = pend_d;
        chk("if_ready", 32'(if_ready), 32'(c == exp_if_rdy));
        chk("if_rdata", if_rdata, held_if);
        chk("d_ready", 32'(d_ready), 32'(c == exp_d_rdy));
        chk("d_rdata", d_rdata, held_d);
        chk("stall_if", 32'(stall_if), 32'(if_req && (c != exp_if_rdy)));
        chk("stall_mem", 32'(stall_mem), 32'(d_req && (c != exp_d_rdy)));
        if (if_ready === 1'b1) t_if_last = c;
        if (d_ready === 1'b1)  t_d_last  = c;
        if (c == exp_if_rdy) if_req = 1'b0;
        if (c == exp_d_rdy)  d_req  = 1'b0;
        if (!if_req && (rate_if != 0) && ($urandom_range(1, 100) <= rate_if)) new_fetch();
        if (!d_req && (rate_d != 0) && ($urandom_range(1, 100) <= rate_d)) new_data();
    endtask

    task automatic wait_idle();
        rate_if = 0;
        rate_d  = 0;
        for (int i = 0; i < 60; i++) begin
            if (!if_req && !d_req && (c >= free_at)) break;
            step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_be"}, 32'(ram_be), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
        chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int n_en;
        int nd;
        logic [31:0] u1_word;

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        u1_if_req = 1'b0; u1_if_addr = '0;
        u1_d_req = 1'b0; u1_d_we = 1'b0; u1_d_addr = '0; u1_d_wdata = '0; u1_d_be = '0;
        u1_ram_rdata = '0;
        rate_if = 0; rate_d = 0;
        t_if_last = -1; t_d_last = -1;
        pend_if = '0; pend_d = '0;
        exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; exp_be = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        c = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        model_reset();

        // Single fetch from 0x10.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        start = c;
        n_en = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (ram_en === 1'b1) n_en++;
        end
        chk("fetch_latency", 32'(t_if_last - start), 32'd4);
        chk("fetch_en_pulses", 32'(n_en), 32'd1);
        chk("fetch_data", if_rdata, 32'h0051_0093);

        // Data write with partial byte enables, then read it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        start = c;
        for (int i = 0; i < 7; i++) step();
        chk("write_latency", 32'(t_d_last - start), 32'd4);
        chk("write_rdata", d_rdata, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        for (int i = 0; i < 7; i++) step();
        chk("readback", d_rdata, {init_word(0) & 32'hFFFF_0000} | 32'h0000_BEEF);

        // Simultaneous requests: data first, fetch one access later.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008; d_be = 4'hF;
        start = c;
        for (int i = 0; i < 12; i++) step();
        chk("simul_d_latency", 32'(t_d_last - start), 32'd4);
        chk("simul_if_latency", 32'(t_if_last - start), 32'd9);

        // Starvation guard with both ports continuously requesting.
        rate_if = 100; rate_d = 100;
        new_fetch();
        new_data();
        nd = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (d_ready === 1'b1) nd++;
            if (if_ready === 1'b1) break;
        end
        chk("starve_data_grants", 32'(nd), 32'(SMAX));
        for (int i = 0; i < 20; i++) begin
            step();
            if ((if_ready === 1'b1) || (d_ready === 1'b1)) break;
        end
        chk("starve_resume_data", 32'(d_ready), 32'd1);
        wait_idle();

        // Random mixed traffic.
        rate_if = 40; rate_d = 50;
        for (int i = 0; i < 1500; i++) step();
        wait_idle();

        // Reset in the middle of a fetch's WAIT phase.
        if_req = 1'b1; if_addr = 32'h0000_0024;
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        if_req = 1'b0;
        d_req  = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
        model_reset();
        if_req = 1'b1; if_addr = 32'h0000_0024;
        start = c;
        for (int i = 0; i < 7; i++) step();
        chk("post_rst_latency", 32'(t_if_last - start), 32'd4);
        chk("post_rst_data", if_rdata, ref_mem[9]);

        // MEM_LAT=1 build: single data read.
        u1_word = 32'h1357_9BDF;
        u1_d_req = 1'b1; u1_d_we = 1'b0; u1_d_addr = 32'h40; u1_d_be = 4'hF; u1_d_wdata = '0;
        u1_ram_rdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("lat1_ram_en", 32'(u1_ram_en), 32'(k == 1));
            chk("lat1_d_ready", 32'(u1_d_ready), 32'(k == 3));
            if (k == 1) chk("lat1_ram_addr", u1_ram_addr, 32'h40);
            if (k == 3) begin
                chk("lat1_d_rdata", u1_d_rdata, u1_word);
                u1_d_req = 1'b0;
            end
            u1_ram_rdata = (k == 2) ? u1_word : $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
